// File: rtl/audio_pkg.sv
// Shared audio-path types: the canonical sample type and the delay-line controller states.
package audio_pkg;

   localparam int SAMPLE_W = 16;

   typedef logic signed [SAMPLE_W-1:0] sample_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      OUT  = 2'd2
   } state_t;

endpackage

// File: rtl/block_ram.sv
// Simple dual-port RAM: one-cycle registered read, read-first on an address collision.
module block_ram #(
   parameter  int W  = 16,
   parameter  int L  = 1024,
   localparam int AW = $clog2(L)
) (
   input  logic          clk,
   input  logic [AW-1:0] rd_addr,
   output logic [W-1:0]  rd_data,
   input  logic          wr_ena,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data
);

   logic [W-1:0] mem [L];

   // Both updates are non-blocking, so a same-address read returns the old word.
   always_ff @(posedge clk) begin
      if (wr_ena) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/delay_line_ctrl.sv
// Audio delay-line controller: writes each sample into an external RAM and returns
// the dry sample together with the sample delayed by the requested number of slots.
module delay_line_ctrl
   import audio_pkg::*;
#(
   parameter  int W  = 16,
   parameter  int L  = 1024,
   localparam int AW = $clog2(L)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_sample,
   input  logic [AW-1:0] delay,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_dry,
   output logic [W-1:0]  out_wet,
   output logic [AW-1:0] ram_rd_addr,
   input  logic [W-1:0]  ram_rd_data,
   output logic          ram_wr_ena,
   output logic [AW-1:0] ram_wr_addr,
   output logic [W-1:0]  ram_wr_data
);

   state_t        state_reg, state_next;
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] delay_reg;
   logic [AW:0]   fill_reg;
   logic [W-1:0]  dry_reg;
   logic [W-1:0]  wet_reg;
   logic          accept;
   logic          release_out;

   assign accept      = in_valid && (state_reg == IDLE);
   assign release_out = out_ready && (state_reg == OUT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE:    if (in_valid)  state_next = WAIT;
         WAIT:    state_next = OUT;
         OUT:     if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // The write strobe is gated by rst_n so it stays low while reset is held.
   always_comb begin
      in_ready   = (state_reg == IDLE);
      out_valid  = (state_reg == OUT);
      ram_wr_ena = accept && rst_n;
   end

   assign ram_wr_addr = wr_ptr_reg;
   assign ram_wr_data = in_sample;
   assign ram_rd_addr = wr_ptr_reg - delay;
   assign out_dry     = dry_reg;
   assign out_wet     = wet_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         fill_reg   <= '0;
         delay_reg  <= '0;
         dry_reg    <= '0;
         wet_reg    <= '0;
      end else begin
         if (accept) begin
            dry_reg   <= in_sample;
            delay_reg <= delay;
         end
         // Zero delay reads the slot being written, which still holds the old word.
         if (state_reg == WAIT) begin
            if (delay_reg == '0) begin
               wet_reg <= dry_reg;
            end else if (fill_reg < {1'b0, delay_reg}) begin
               wet_reg <= '0;
            end else begin
               wet_reg <= ram_rd_data;
            end
         end
         if (release_out) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (fill_reg != (AW+1)'(L)) begin
               fill_reg <= fill_reg + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Scoreboard bench for delay_line_ctrl paired with a 16-deep block_ram.
module tb_delay_line_ctrl;

   localparam int W  = 16;
   localparam int L  = 16;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_sample = '0;
   logic [AW-1:0] delay = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_dry;
   logic [W-1:0]  out_wet;
   logic [AW-1:0] ram_rd_addr;
   logic [W-1:0]  ram_rd_data;
   logic          ram_wr_ena;
   logic [AW-1:0] ram_wr_addr;
   logic [W-1:0]  ram_wr_data;

   int            total = 0;
   int            bad = 0;
   int            wr_count = 0;
   int            txn = 0;
   bit            rand_ready = 1'b0;
   logic [W-1:0]  exp_dry_q[$];
   logic [W-1:0]  exp_wet_q[$];
   logic [W-1:0]  hist[$];
   logic [W-1:0]  mon_d, mon_w;

   always #5 clk = ~clk;

   delay_line_ctrl #(.W(W), .L(L)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample), .delay(delay),
      .out_valid(out_valid), .out_ready(out_ready), .out_dry(out_dry), .out_wet(out_wet),
      .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
      .ram_wr_ena(ram_wr_ena), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data)
   );

   block_ram #(.W(W), .L(L)) ram (
      .clk(clk), .rd_addr(ram_rd_addr), .rd_data(ram_rd_data),
      .wr_ena(ram_wr_ena), .wr_addr(ram_wr_addr), .wr_data(ram_wr_data)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, req);
      end
   endtask

   // Reference: the wet sample is simply the sample accepted d transactions earlier.
   function automatic logic [W-1:0] model_wet(input logic [W-1:0] s, input int d);
      if (d == 0) return s;
      if (hist.size() < d) return '0;
      return hist[hist.size() - d];
   endfunction

   always @(posedge clk) begin
      if (ram_wr_ena) wr_count++;
   end

   always @(posedge clk) begin
      if (rand_ready) begin
         #2 out_ready = 1'($urandom_range(0, 1));
      end
   end

   // Monitor: one comparison pair per completed output handshake.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_dry_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: got dry=%0h wet=%0h, want no output", out_dry, out_wet);
         end else begin
            mon_d = exp_dry_q.pop_front();
            mon_w = exp_wet_q.pop_front();
            check("dry", 32'(out_dry), 32'(mon_d));
            check("wet", 32'(out_wet), 32'(mon_w));
            hist.push_back(mon_d);
            txn++;
            $display("txn %0d: dry=%0d wet=%0d (want wet=%0d)", txn,
                     $signed(out_dry), $signed(out_wet), $signed(mon_w));
         end
      end
   end

   task automatic send(input logic [W-1:0] s, input int d);
      int n = 0;
      in_sample = s;
      delay     = AW'(d);
      in_valid  = 1'b1;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: got in_ready=0, want 1");
         in_valid = 1'b0;
         return;
      end
      exp_dry_q.push_back(s);
      exp_wet_q.push_back(model_wet(s, d));
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_dry_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (exp_dry_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d pending, want 0", exp_dry_q.size());
         exp_dry_q.delete();
         exp_wet_q.delete();
      end
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_out_valid"},  32'(out_valid), 32'd0);
      check({tag, "_out_dry"},    32'(out_dry), 32'd0);
      check({tag, "_out_wet"},    32'(out_wet), 32'd0);
      check({tag, "_in_ready"},   32'(in_ready), 32'd1);
      check({tag, "_ram_wr_ena"}, 32'(ram_wr_ena), 32'd0);
   endtask

   initial begin
      int base;
      // Power-on reset, with in_valid raised to confirm no write leaks out during reset.
      #12;
      in_valid = 1'b1;
      #1;
      check_reset_outputs("por");
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      out_ready = 1'b1;
      for (int k = 1; k <= 20; k++) send(W'(k), 3);
      drain();

      send(W'(100), 0);
      send(W'(-5), 0);
      drain();

      for (int k = 1; k <= 40; k++) send(W'(k * 7), 15);
      drain();

      // Backpressure: stalled output must hold and block further accepts.
      out_ready = 1'b0;
      base = wr_count;
      send(W'(16'h1234), 4);
      @(negedge clk);
      for (int c = 0; c < 10; c++) begin
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_out_dry",   32'(out_dry), 32'(exp_dry_q[0]));
         check("bp_out_wet",   32'(out_wet), 32'(exp_wet_q[0]));
         check("bp_in_ready",  32'(in_ready), 32'd0);
         @(negedge clk);
      end
      check("bp_ram_writes", 32'(wr_count - base), 32'd1);
      out_ready = 1'b1;
      drain();

      // Reset while a sample sits in WAIT: it is discarded and history restarts.
      for (int k = 1; k <= 8; k++) send(W'(k), 2);
      drain();
      send(W'(99), 2);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid");
      exp_dry_q.delete();
      exp_wet_q.delete();
      hist.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int k = 9; k <= 11; k++) send(W'(k), 2);
      drain();

      send(W'(7), 2);
      send(W'(8), 5);
      send(W'(9), 5);
      drain();

      rand_ready = 1'b1;
      for (int k = 0; k < 60; k++) send(W'($urandom), int'($urandom_range(0, L - 1)));
      rand_ready = 1'b0;
      #3;
      out_ready = 1'b1;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
